// File: rtl/rcc_lp_pkg.sv
// rcc_lp_pkg: shared state encodings and defaults for the low-power mode controller
package rcc_lp_pkg;
    typedef enum logic [1:0] {C_RUN, C_SLEEP, C_DSLEEP} cpu_lp_state_t;
    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_STOP, S_WAKE} sys_lp_state_t;
    localparam int WAKE_DLY_DEF = 16;
endpackage

// File: rtl/rcc_lp_mode_ctrl_cpu_lp_fsm.sv
// rcc_cpu_lp_fsm: per-CPU run/sleep/deepsleep sequencer with deferred wake while the system is stopped
module rcc_cpu_lp_fsm
    import rcc_lp_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic sleep_req,
    input  logic sleepdeep,
    input  logic wakeup,
    input  logic sys_in_run,
    output logic sleep,
    output logic deepsleep,
    output logic in_dsleep
);
    cpu_lp_state_t state, nxt;
    logic pend, pend_nxt;
    always_comb begin
        nxt = state;
        pend_nxt = pend;
        case (state)
            C_RUN:    if (sleep_req && !wakeup) nxt = sleepdeep ? C_DSLEEP : C_SLEEP;
            C_SLEEP:  if (wakeup) nxt = C_RUN;
            C_DSLEEP: begin
                // a wake seen while the system is stopped is remembered until it is back in run
                if ((wakeup || pend) && sys_in_run) begin
                    nxt = C_RUN;
                    pend_nxt = 1'b0;
                end else if (wakeup) begin
                    pend_nxt = 1'b1;
                end
            end
            default:  nxt = C_RUN;
        endcase
    end
    assign in_dsleep = state == C_DSLEEP && nxt == C_DSLEEP;
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= C_RUN;
            pend <= 1'b0;
            sleep <= 1'b0;
            deepsleep <= 1'b0;
        end else begin
            state <= nxt;
            pend <= pend_nxt;
            sleep <= nxt != C_RUN;
            deepsleep <= nxt == C_DSLEEP;
        end
    end
endmodule

// File: rtl/rcc_lp_mode_ctrl.sv
// rcc_lp_mode_ctrl: CPU sleep, domain stop and system stop/wake sequencing on the ungated clock
module rcc_lp_mode_ctrl
    import rcc_lp_pkg::*;
#(
    parameter int WAKE_DLY   = WAKE_DLY_DEF,
    parameter int WAKE_CNT_W = 8
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic c1_sleep_req,
    input  logic c1_sleepdeep,
    input  logic c1_wakeup,
    input  logic c2_sleep_req,
    input  logic c2_sleepdeep,
    input  logic c2_wakeup,
    input  logic d1_busy,
    input  logic d2_busy,
    input  logic flash_busy,
    input  logic sys_stop_en,
    output logic c1_sleep,
    output logic c1_deepsleep,
    output logic c2_sleep,
    output logic c2_deepsleep,
    output logic rcc_d1_stop,
    output logic rcc_d2_stop,
    output logic rcc_sys_stop,
    output logic stop_abort
);
    sys_lp_state_t sys_state, sys_nxt;
    logic [WAKE_CNT_W-1:0] wake_cnt;
    logic any_wakeup, wake_done, sys_in_run, abort, c1_in_dsleep, c2_in_dsleep;
    assign any_wakeup = c1_wakeup | c2_wakeup;
    assign wake_done = sys_state == S_WAKE && wake_cnt == WAKE_CNT_W'(WAKE_DLY - 1);
    // the release edge out of S_WAKE already counts as run so waking CPUs leave deepsleep on it
    assign sys_in_run = sys_state == S_RUN || sys_state == S_DRAIN || wake_done;
    assign abort = sys_state == S_DRAIN && (any_wakeup || !sys_stop_en);
    rcc_cpu_lp_fsm u_c1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sleep_req(c1_sleep_req), .sleepdeep(c1_sleepdeep),
        .wakeup(c1_wakeup), .sys_in_run(sys_in_run), .sleep(c1_sleep), .deepsleep(c1_deepsleep),
        .in_dsleep(c1_in_dsleep)
    );
    rcc_cpu_lp_fsm u_c2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sleep_req(c2_sleep_req), .sleepdeep(c2_sleepdeep),
        .wakeup(c2_wakeup), .sys_in_run(sys_in_run), .sleep(c2_sleep), .deepsleep(c2_deepsleep),
        .in_dsleep(c2_in_dsleep)
    );
    always_comb begin
        sys_nxt = sys_state;
        case (sys_state)
            S_RUN:   if (rcc_d1_stop && rcc_d2_stop && sys_stop_en) sys_nxt = S_DRAIN;
            S_DRAIN: sys_nxt = abort ? S_RUN : flash_busy ? S_DRAIN : S_STOP;
            S_STOP:  if (any_wakeup) sys_nxt = S_WAKE;
            S_WAKE:  if (wake_done) sys_nxt = S_RUN;
            default: sys_nxt = S_RUN;
        endcase
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sys_state <= S_RUN;
            wake_cnt <= '0;
            rcc_d1_stop <= 1'b0;
            rcc_d2_stop <= 1'b0;
            rcc_sys_stop <= 1'b0;
            stop_abort <= 1'b0;
        end else begin
            sys_state <= sys_nxt;
            wake_cnt <= sys_state != S_WAKE ? '0 : &wake_cnt ? wake_cnt : wake_cnt + 1'b1;
            rcc_d1_stop <= sys_state != S_WAKE && c1_in_dsleep && (rcc_d1_stop || !d1_busy);
            rcc_d2_stop <= sys_state != S_WAKE && c2_in_dsleep && (rcc_d2_stop || !d2_busy);
            rcc_sys_stop <= sys_nxt == S_STOP;
            stop_abort <= abort;
        end
    end
endmodule

// File: tb/tb_rcc_lp_mode_ctrl.sv
// tb_rcc_lp_mode_ctrl: directed and random stimulus scored against a rule-level model
module tb_rcc_lp_mode_ctrl;
    localparam int WD = 16;
    logic sys_clk = 1'b0, sys_rst = 1'b1;
    logic c1_sleep_req = 0, c1_sleepdeep = 0, c1_wakeup = 0, c2_sleep_req = 0, c2_sleepdeep = 0, c2_wakeup = 0;
    logic d1_busy = 0, d2_busy = 0, flash_busy = 0, sys_stop_en = 0;
    logic c1_sleep, c1_deepsleep, c2_sleep, c2_deepsleep, rcc_d1_stop, rcc_d2_stop, rcc_sys_stop, stop_abort;
    int total = 0, bad = 0;
    logic [7:0] exp_q[$];
    int mode[2];
    bit pend[2], dstop[2];
    int sys, wake_left;
    bit sstop, sabort;

    always #5 sys_clk = ~sys_clk;

    rcc_lp_mode_ctrl dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .c1_sleep_req(c1_sleep_req), .c1_sleepdeep(c1_sleepdeep), .c1_wakeup(c1_wakeup),
        .c2_sleep_req(c2_sleep_req), .c2_sleepdeep(c2_sleepdeep), .c2_wakeup(c2_wakeup),
        .d1_busy(d1_busy), .d2_busy(d2_busy), .flash_busy(flash_busy), .sys_stop_en(sys_stop_en),
        .c1_sleep(c1_sleep), .c1_deepsleep(c1_deepsleep), .c2_sleep(c2_sleep), .c2_deepsleep(c2_deepsleep),
        .rcc_d1_stop(rcc_d1_stop), .rcc_d2_stop(rcc_d2_stop), .rcc_sys_stop(rcc_sys_stop), .stop_abort(stop_abort)
    );

    // model: cpu mode 0 run / 1 sleep / 2 deep; sys 0 run / 1 drain / 2 stop / 3 wake with a countdown
    task automatic model(input logic [10:0] v);
        bit rst, r1, s1, w1, r2, s2, w2, b1, b2, fb, en, allowed;
        bit req[2], sd[2], wk[2], busy[2], old_dstop[2];
        int old_mode;
        {rst, r1, s1, w1, r2, s2, w2, b1, b2, fb, en} = v;
        if (rst) begin
            mode = '{0, 0}; pend = '{0, 0}; dstop = '{0, 0};
            sys = 0; wake_left = 0; sstop = 0; sabort = 0;
            return;
        end
        req = '{r1, r2}; sd = '{s1, s2}; wk = '{w1, w2}; busy = '{b1, b2};
        allowed = sys <= 1 || (sys == 3 && wake_left == 1);
        old_dstop = dstop;
        for (int i = 0; i < 2; i++) begin
            old_mode = mode[i];
            case (mode[i])
                0: if (req[i] && !wk[i]) mode[i] = sd[i] ? 2 : 1;
                1: if (wk[i]) mode[i] = 0;
                default: begin
                    if ((wk[i] || pend[i]) && allowed) begin
                        mode[i] = 0;
                        pend[i] = 0;
                    end else if (wk[i]) pend[i] = 1;
                end
            endcase
            dstop[i] = sys != 3 && old_mode == 2 && mode[i] == 2 && (old_dstop[i] || !busy[i]);
        end
        sabort = 0;
        case (sys)
            0: if (old_dstop[0] && old_dstop[1] && en) sys = 1;
            1: begin
                if (w1 || w2 || !en) begin sys = 0; sabort = 1; end
                else if (!fb) sys = 2;
            end
            2: if (w1 || w2) begin sys = 3; wake_left = WD; end
            default: begin
                wake_left--;
                if (wake_left == 0) sys = 0;
            end
        endcase
        sstop = sys == 2;
    endtask

    task automatic step(input logic [10:0] v, input int n);
        repeat (n) begin
            @(negedge sys_clk);
            {sys_rst, c1_sleep_req, c1_sleepdeep, c1_wakeup, c2_sleep_req, c2_sleepdeep, c2_wakeup,
             d1_busy, d2_busy, flash_busy, sys_stop_en} = v;
            model(v);
            exp_q.push_back({mode[0] != 0, mode[0] == 2, mode[1] != 0, mode[1] == 2, dstop[0], dstop[1], sstop, sabort});
        end
    endtask

    initial begin
        logic [7:0] e, a;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {c1_sleep, c1_deepsleep, c2_sleep, c2_deepsleep, rcc_d1_stop, rcc_d2_stop, rcc_sys_stop, stop_abort};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got=%b exp=%b (c1s c1d c2s c2d d1 d2 sys abort)", $time, a, e);
                end
            end
        end
    end

    initial begin
        // vector order: rst r1 sd1 w1 r2 sd2 w2 b1 b2 flash en
        step(11'b1_000_000_00_0_0, 2);
        step(11'b0_100_000_00_0_0, 3);
        step(11'b0_001_000_00_0_0, 1);
        step(11'b0_000_000_00_0_0, 2);
        step(11'b0_101_000_00_0_0, 2);
        step(11'b0_110_000_11_0_0, 6);
        step(11'b0_110_000_01_0_0, 3);
        step(11'b0_110_110_00_0_1, 8);
        step(11'b0_110_001_00_0_1, 1);
        step(11'b0_110_000_00_0_1, 22);
        step(11'b0_110_110_00_1_1, 6);
        step(11'b0_001_000_00_1_1, 1);
        step(11'b0_000_000_00_1_1, 3);
        step(11'b0_110_110_00_0_1, 8);
        step(11'b0_110_001_00_0_1, 1);
        step(11'b0_110_000_00_0_1, 7);
        step(11'b1_110_000_00_0_1, 1);
        step(11'b0_110_110_00_0_1, 8);
        step(11'b0_110_001_00_0_1, 1);
        step(11'b0_110_000_00_0_1, 20);
        step(11'b0_110_110_00_1_1, 5);
        step(11'b0_110_110_00_1_0, 2);
        for (int k = 0; k < 3000; k++)
            step({$urandom_range(0, 299) == 0, $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 85,
                  $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 85,
                  $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 90}, 1);
        @(negedge sys_clk);
        @(negedge sys_clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0 pending", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rcc_lp_mode_ctrl.md
Name: rcc_lp_mode_ctrl

Overview:
- Low-power mode controller. It produces the sleep, deepsleep and stop controls that the system clock generator consumes: c1_sleep, c1_deepsleep, c2_sleep, c2_deepsleep, rcc_d1_stop, rcc_d2_stop and rcc_sys_stop.
- It takes CPU WFI/SLEEPDEEP requests, bridge and flash busy indications, and wakeup events. From these it sequences CPU sleep, domain stop and system stop/wake with a drain-then-stop handshake.
- It runs on the ungated system clock source, so it keeps operating while gated clocks are stopped.

Parameters:
- WAKE_DLY, default 16: cycles held in system wake state before clocks are released (oscillator restart margin). Legal range 1..2^WAKE_CNT_W-1.
- WAKE_CNT_W, default 8: width of the wake counter.

Ports:
- sys_clk  in  1  ungated system clock source.
- sys_rst  in  1  synchronous reset, active-high.
- c1_sleep_req  in  1  CPU1 WFI/WFE, level.
- c1_sleepdeep  in  1  CPU1 SLEEPDEEP bit.
- c1_wakeup  in  1  CPU1 interrupt/event, level.
- c2_sleep_req  in  1  CPU2 WFI/WFE, level.
- c2_sleepdeep  in  1  CPU2 SLEEPDEEP bit.
- c2_wakeup  in  1  CPU2 interrupt/event, level.
- d1_busy  in  1  OR of axibridge_d1_busy, ahb3bridge_d1_busy and apb3bridge_d1_busy, combined at top level.
- d2_busy  in  1  OR of ahb1/ahb2/apb1/apb2 bridge_d2 busy, combined at top level.
- flash_busy  in  1  flash operation in progress.
- sys_stop_en  in  1  PWR permits system stop.
- c1_sleep  out  1  to clock generator.
- c1_deepsleep  out  1  to clock generator.
- c2_sleep  out  1  to clock generator.
- c2_deepsleep  out  1  to clock generator.
- rcc_d1_stop  out  1  D1 domain stopped.
- rcc_d2_stop  out  1  D2 domain stopped.
- rcc_sys_stop  out  1  system clock stopped.
- stop_abort  out  1  one-cycle pulse when a drain is aborted by wakeup.

Behaviour:
- All outputs are registered. Reset value of every output is 0, and both CPU FSMs and the system FSM reset to their run state.
- Port naming on this block is fixed: clock is sys_clk, reset is sys_rst, one clock, synchronous active-high reset.
- Per-CPU FSM (states C_RUN, C_SLEEP, C_DSLEEP):
  - C_RUN: if sleep_req=1 and wakeup=0, go to C_DSLEEP when sleepdeep=1, else to C_SLEEP. Outputs update one cycle after sleep_req is sampled.
  - C_SLEEP: outputs sleep=1, deepsleep=0. wakeup=1 returns to C_RUN next cycle.
  - C_DSLEEP: outputs sleep=1, deepsleep=1. wakeup=1 returns to C_RUN next cycle only if the system FSM is in S_RUN or S_DRAIN. Otherwise the CPU is held until the system FSM returns to S_RUN.
  - sleep_req and wakeup asserted in the same cycle: wakeup wins and the CPU stays in C_RUN.
- Domain stop:
  - rcc_d1_stop is set when C1 is in C_DSLEEP and d1_busy=0 for one sampled cycle.
  - rcc_d2_stop is set likewise for C2 with d2_busy.
  - Each domain stop clears in the same cycle its CPU leaves C_DSLEEP, and is also forced to 0 whenever the system FSM is in S_WAKE.
- System FSM (states S_RUN, S_DRAIN, S_STOP, S_WAKE):
  - S_RUN -> S_DRAIN when rcc_d1_stop=1, rcc_d2_stop=1 and sys_stop_en=1.
  - S_DRAIN -> S_STOP when flash_busy=0. rcc_sys_stop rises on that transition.
  - Any wakeup while in S_DRAIN returns to S_RUN and emits a 1-cycle stop_abort pulse.
  - S_STOP holds rcc_sys_stop=1. Any wakeup moves to S_WAKE.
  - S_WAKE drops rcc_sys_stop to 0 on entry, counts WAKE_DLY cycles, then returns to S_RUN.
  - On the S_WAKE -> S_RUN transition the waking CPU(s) return to C_RUN and both domain stops clear. A non-waking CPU re-enters its domain stop later per the domain rules.
  - sys_stop_en dropping in S_DRAIN aborts the drain exactly like a wakeup. sys_stop_en dropping in S_STOP is ignored.
- Wake counter saturates and never wraps. The count restarts from 0 on each S_WAKE entry.
- Reset asserted mid-sequence (any state) returns everything to run with all outputs 0 on the next edge.

Decomposition:
- Shared package rcc_lp_pkg holds:
  - cpu_lp_state_t enum (C_RUN, C_SLEEP, C_DSLEEP);
  - sys_lp_state_t enum (S_RUN, S_DRAIN, S_STOP, S_WAKE);
  - WAKE_DLY default constant.
- Sub-module rcc_cpu_lp_fsm is instantiated twice, once per CPU.
  - Inputs: sleep_req, sleepdeep, wakeup, sys_in_run.
  - Outputs: sleep, deepsleep, in_dsleep.

Test Plan:
- Sleep entry and wake: c1_sleep_req=1 with c1_sleepdeep=0 -> c1_sleep=1 next cycle and c1_deepsleep=0. c1_wakeup pulse -> c1_sleep=0 next cycle. No domain or system stop occurs.
- Domain drain: c1 deepsleep with d1_busy=1 for 5 cycles -> rcc_d1_stop stays 0. d1_busy then drops to 0 -> rcc_d1_stop=1 next cycle.
- Full stop/wake: both CPUs in deepsleep, busies 0, sys_stop_en=1, flash_busy=0 -> rcc_sys_stop=1 within 3 cycles. Then c2_wakeup -> rcc_sys_stop=0 next cycle; with WAKE_DLY=16, exactly 16 cycles later c2 returns to run and both domain stops clear. c1 remains deepsleep and rcc_d1_stop re-asserts later per the domain rules.
- Drain abort: in S_DRAIN with flash_busy=1, assert c1_wakeup -> stop_abort=1 for exactly 1 cycle, rcc_sys_stop never asserts, c1_sleep=0.
- Simultaneous sleep_req and wakeup in the same cycle -> CPU stays in run and all outputs stay 0.
- Reset during S_WAKE at count 7 -> all outputs 0 next edge. A subsequent deepsleep sequence behaves identically to the post-reset case.
